// File: rtl/blit_inner_seq.sv
// Inner-loop memory-cycle sequencer for the blitter.
// Each inner step issues an optional source read, an optional extra source
// read, an optional destination read and always a destination write, then
// repeats until the loaded count is exhausted or an abort is seen.
module blit_inner_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] icount,
  input  logic             srcen,
  input  logic             srcenx,
  input  logic             dsten,
  input  logic             phrase_mode,
  input  logic             memready,
  input  logic             memidle,
  output logic             readreq,
  output logic             writereq,
  output logic             sread_1,
  output logic             sreadx_1,
  output logic             dread_1,
  output logic             phrase_cycle,
  output logic             step_inner,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] count_rem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SREAD  = 3'd1,
    SREADX = 3'd2,
    DREAD  = 3'd3,
    DWRITE = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t state;

  // Enables captured at start; srcenx_q already qualified by srcen.
  logic srcen_q;
  logic srcenx_q;
  logic dsten_q;

  // First bus cycle of a step (also the stage that follows an extra
  // source read when called with s=0).
  function automatic state_t first_stage(input logic s, input logic d);
    if (s)      return SREAD;
    else if (d) return DREAD;
    else        return DWRITE;
  endfunction

  // Stage that follows the plain source read.
  function automatic state_t after_sread(input logic sx, input logic d);
    if (sx) return SREADX;
    else    return first_stage(1'b0, d);
  endfunction

  // Request strobes decode straight from state so a read-to-read hand-off
  // keeps readreq high without a gap.
  assign readreq  = (state == SREAD) || (state == SREADX) || (state == DREAD);
  assign writereq = (state == DWRITE);
  assign sread_1  = (state == SREAD);
  assign sreadx_1 = (state == SREADX);
  assign dread_1  = (state == DREAD);
  assign busy     = (state != IDLE);

  // Sequencer state, latched operands and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      srcen_q      <= 1'b0;
      srcenx_q     <= 1'b0;
      dsten_q      <= 1'b0;
      phrase_cycle <= 1'b0;
      step_inner   <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      count_rem    <= '0;
    end else begin
      step_inner <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          // Abort in the same cycle as start suppresses the start.
          if (start && !abort) begin
            srcen_q      <= srcen;
            srcenx_q     <= srcen & srcenx;
            dsten_q      <= dsten;
            phrase_cycle <= phrase_mode;
            count_rem    <= icount;
            aborted      <= 1'b0;
            if (icount == '0) state <= FIN;
            else              state <= first_stage(srcen, dsten);
          end
        end
        SREAD: begin
          if (memready) begin
            if (abort) begin
              aborted <= 1'b1;
              state   <= FIN;
            end else begin
              state <= after_sread(srcenx_q, dsten_q);
            end
          end
        end
        SREADX: begin
          if (memready) begin
            if (abort) begin
              aborted <= 1'b1;
              state   <= FIN;
            end else begin
              state <= first_stage(1'b0, dsten_q);
            end
          end
        end
        DREAD: begin
          if (memready) begin
            if (abort) begin
              aborted <= 1'b1;
              state   <= FIN;
            end else begin
              state <= DWRITE;
            end
          end
        end
        DWRITE: begin
          // A completed write always counts, even if abort ends the loop.
          if (memready) begin
            step_inner <= 1'b1;
            if (count_rem != '0) count_rem <= count_rem - CNT_W'(1);
            if (abort) begin
              aborted <= 1'b1;
              state   <= FIN;
            end else if (count_rem <= CNT_W'(1)) begin
              state <= FIN;
            end else begin
              state <= first_stage(srcen_q, dsten_q);
            end
          end
        end
        FIN: begin
          // Hold off completion until the controller has drained.
          if (memidle) begin
            done         <= 1'b1;
            phrase_cycle <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_blit_inner_seq.sv
// Directed bench for blit_inner_seq with a configurable-latency memory
// responder and a cycle monitor that condenses the request sequence.
module tb_blit_inner_seq;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] icount = '0;
  logic             srcen = 1'b0;
  logic             srcenx = 1'b0;
  logic             dsten = 1'b0;
  logic             phrase_mode = 1'b0;
  logic             memready = 1'b0;
  logic             memidle = 1'b1;
  logic             readreq, writereq, sread_1, sreadx_1, dread_1;
  logic             phrase_cycle, step_inner, busy, done, aborted;
  logic [CNT_W-1:0] count_rem;

  blit_inner_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .icount(icount),
    .srcen(srcen), .srcenx(srcenx), .dsten(dsten), .phrase_mode(phrase_mode),
    .memready(memready), .memidle(memidle), .readreq(readreq),
    .writereq(writereq), .sread_1(sread_1), .sreadx_1(sreadx_1),
    .dread_1(dread_1), .phrase_cycle(phrase_cycle), .step_inner(step_inner),
    .busy(busy), .done(done), .aborted(aborted), .count_rem(count_rem)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acknowledges a request after 'delay' extra cycles.
  int delay = 0;
  int rcnt  = 0;
  always @(negedge clk) begin
    if (reset) begin
      rcnt     = 0;
      memready = 1'b0;
    end else begin
      if (memready) rcnt = 0;
      if (readreq || writereq) begin
        rcnt++;
        memready = (rcnt > delay);
      end else begin
        rcnt     = 0;
        memready = 1'b0;
      end
    end
  end

  // Monitor: octal-packed sequence of distinct request codes, pulse counts,
  // count_rem at each step, longest readreq run and decode consistency.
  int          step_cnt, done_cnt, rd_run, max_run, oh_err, phr_err, last_code;
  logic [63:0] seq, cr_seq;
  always @(posedge clk) begin
    int code;
    #1;
    code = sread_1 ? 1 : sreadx_1 ? 2 : dread_1 ? 3 : writereq ? 4 : 0;
    if (code != 0 && code != last_code) seq = (seq << 3) | 64'(code);
    last_code = code;
    if (step_inner) begin
      step_cnt++;
      cr_seq = (cr_seq << 4) | 64'(count_rem);
    end
    if (done) done_cnt++;
    if (readreq) begin
      rd_run++;
      if (rd_run > max_run) max_run = rd_run;
    end else begin
      rd_run = 0;
    end
    if ((int'(sread_1) + int'(sreadx_1) + int'(dread_1) + int'(writereq)) > 1 ||
        readreq != (sread_1 | sreadx_1 | dread_1)) oh_err++;
    if (busy && !phrase_cycle) phr_err++;
  end

  task automatic clear_mon();
    step_cnt = 0; done_cnt = 0; rd_run = 0; max_run = 0; oh_err = 0;
    phr_err = 0; last_code = 0; seq = '0; cr_seq = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input int cnt, input logic s, input logic sx,
                          input logic d, input logic ph);
    icount = CNT_W'(cnt); srcen = s; srcenx = sx; dsten = d; phrase_mode = ph;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string tag);
    int i = 0;
    while (done_cnt == 0 && i < bound) begin
      @(negedge clk);
      i++;
    end
    check(tag, done_cnt, 1);
  endtask

  initial begin
    int i;
    clear_mon();
    // Reset values
    tick(3);
    check("rst_outs", {readreq, writereq, sread_1, sreadx_1, dread_1,
                       phrase_cycle, step_inner, busy, done, aborted}, 0);
    check("rst_cnt", count_rem, 0);
    reset = 1'b0;
    tick(1);

    // T1: 3 steps of SREAD,DWRITE with one-cycle memory latency
    clear_mon(); delay = 1;
    do_start(3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t1_cnt_init", count_rem, 3);
    check("t1_busy", busy, 1);
    wait_done(100, "t1_done");
    check("t1_seq", seq, 64'o141414);
    check("t1_steps", step_cnt, 3);
    check("t1_cnt_trace", cr_seq, 64'h210);
    check("t1_busy_after", busy, 0);
    check("t1_cnt_end", count_rem, 0);
    tick(2);
    check("t1_done_once", done_cnt, 1);

    // T2: all reads enabled, memready immediate
    clear_mon(); delay = 0;
    do_start(2, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_done(100, "t2_done");
    check("t2_seq", seq, 64'o12341234);
    check("t2_rd_run", max_run, 3);
    check("t2_steps", step_cnt, 2);
    check("t2_onehot", oh_err, 0);

    // T3: zero count, done held off by memidle
    clear_mon(); memidle = 1'b0;
    do_start(0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick(3);
    check("t3_busy_fin", busy, 1);
    check("t3_no_done", done_cnt, 0);
    memidle = 1'b1;
    wait_done(20, "t3_done");
    check("t3_no_req", seq, 0);
    check("t3_cnt", count_rem, 0);
    check("t3_steps", step_cnt, 0);

    // Start with abort in the same cycle: nothing starts
    clear_mon();
    icount = CNT_W'(5); srcen = 1'b1; abort = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tick(2);
    check("sa_busy", busy, 0);
    check("sa_no_req", seq, 0);
    check("sa_cnt", count_rem, 0);

    // T4: abort during SREAD of step 2, memready after 4 wait cycles
    clear_mon(); delay = 4;
    do_start(5, 1'b1, 1'b0, 1'b0, 1'b0);
    i = 0;
    while (!(step_cnt == 1 && sread_1) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("t4_reach", (step_cnt == 1 && sread_1), 1);
    abort = 1'b1;
    wait_done(100, "t4_done");
    abort = 1'b0;
    check("t4_seq", seq, 64'o141);
    check("t4_steps", step_cnt, 1);
    check("t4_cnt", count_rem, 4);
    check("t4_aborted", aborted, 1);
    check("t4_rd_hold", max_run, 5);

    // T5: second start while busy ignored, then reset mid-DWRITE
    clear_mon(); delay = 3;
    do_start(4, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_abort_clr", aborted, 0);
    icount = CNT_W'(9); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_ignored", count_rem, 4);
    i = 0;
    while (!(step_cnt == 1 && writereq) && i < 200) begin
      @(negedge clk);
      i++;
    end
    check("t5_reach", (step_cnt == 1 && writereq), 1);
    check("t5_cnt_mid", count_rem, 3);
    reset = 1'b1;
    #1;
    check("t5_rst_outs", {readreq, writereq, sread_1, sreadx_1, dread_1,
                          phrase_cycle, step_inner, busy, done, aborted}, 0);
    check("t5_rst_cnt", count_rem, 0);
    tick(3);
    check("t5_no_done", done_cnt, 0);
    reset = 1'b0;
    tick(1);

    // T6: phrase_cycle holds through FIN despite phrase_mode changing
    clear_mon(); delay = 1; memidle = 1'b0;
    do_start(2, 1'b1, 1'b0, 1'b0, 1'b1);
    phrase_mode = 1'b0;
    check("t6_phrase_on", phrase_cycle, 1);
    i = 0;
    while (step_cnt < 2 && i < 100) begin
      @(negedge clk);
      i++;
    end
    check("t6_steps", step_cnt, 2);
    tick(3);
    check("t6_fin_busy", busy, 1);
    check("t6_fin_phrase", phrase_cycle, 1);
    check("t6_fin_nodone", done_cnt, 0);
    memidle = 1'b1;
    wait_done(20, "t6_done");
    check("t6_phrase_off", phrase_cycle, 0);
    check("t6_phrase_hold", phr_err, 0);
    check("t6_busy_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
